dpmem_arbiter: RTL and testbench
================================

Name: dpmem_arbiter

Overview:
- Round-robin arbiter that shares one simpledpmem instance (16-bit data, 1024 words) between two write requesters (A, B) and two read requesters (A, B).
- Write port and read port are arbitrated independently. All memory-side signals are registered.
- A read-return pipeline tags each response with its requester.
- Sits between client blocks and the memory; drives the memory's wr_en/wr_adr/dat_in/rd_adr and consumes its dat_out.

Parameters:
- DW, 16, data width.
- AW, 10, address width.
- RD_LAT, 1, memory read latency in clocks from mem_rd_adr registered to mem_dat_out valid (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wa_req  in  1  writer A request; wa_adr/wa_dat held stable while high.
- wa_adr  in  AW  writer A address.
- wa_dat  in  DW  writer A data.
- wa_gnt  out  1  writer A accepted this cycle.
- wb_req / wb_adr / wb_dat / wb_gnt  same as A, for writer B.
- ra_req  in  1  reader A request.
- ra_adr  in  AW  reader A address.
- ra_gnt  out  1  reader A accepted this cycle.
- ra_vld  out  1  rd_dat holds reader A data this cycle.
- rb_req / rb_adr / rb_gnt / rb_vld  same as A, for reader B.
- rd_dat  out  DW  shared read-return data.
- mem_wr_en  out  1  to memory wr_en.
- mem_wr_adr  out  AW  to memory wr_adr.
- mem_dat_in  out  DW  to memory dat_in.
- mem_rd_adr  out  AW  to memory rd_adr.
- mem_dat_out  in  DW  from memory dat_out.

Behaviour:
- Reset (reset=0, asynchronous): mem_wr_en=0, mem_wr_adr=0, mem_dat_in=0, mem_rd_adr=0, all vld=0, rd_dat=0, write and read priority pointers both point to A. Gnt outputs are combinational and 0 while reset=0.
- Grants are combinational from req and pointer; at most one write grant and one read grant per cycle.
- Write arbitration:
  - Only one requester high: it is granted.
  - Both high: the pointer side is granted.
  - Each write grant moves the write pointer to the other requester. No grant leaves the pointer unchanged.
- Read arbitration: identical rule with its own independent pointer.
- Handshake: gnt is a one-cycle acceptance. A requester holding req high after gnt is treated as a new request next cycle. The grant itself is the only back-pressure; there are no stalls.
- Write path: grant in cycle N gives registered mem_wr_en=1, mem_wr_adr and mem_dat_in in cycle N+1, so the memory writes on the edge ending N+1. With no grant, mem_wr_en=0 in N+1 and adr/dat hold their last values.
- Read path:
  - Grant in cycle N registers mem_rd_adr in N+1.
  - The requester tag travels a valid/tag shift register of depth RD_LAT+1.
  - In cycle N+1+RD_LAT, the matching ra_vld or rb_vld is 1 and rd_dat equals mem_dat_out (registered alongside vld). rd_dat holds its value when no vld.
- Throughput: one write and one read per cycle, sustained. Both requesters continuously high gives strict alternation A,B,A,B.
- Simultaneous write and read to the same address granted in the same cycle: without the optional feature, the returned data is whatever memory returns (old contents for simpledpmem).
- Reset mid-operation: in-flight reads are dropped (no vld after reset release), any pending write is cancelled, pointers return to A.

Optional Feature:
- Macro: DPMEM_ARB_WR_FWD_EN.
- When defined: if a read and a write to the same address are granted in the same cycle, or a read is granted in the cycle after a write to that address, the write data is captured into the read pipeline. That data is returned as rd_dat instead of mem_dat_out.
- When undefined: no forwarding logic; rd_dat is always mem_dat_out.

Test Plan:
- Reset: hold reset=0 with all req=1 -> all gnt=0, mem_wr_en=0, vld=0. Release -> first cycle wa_gnt=1, ra_gnt=1 (pointer at A).
- Single write then read: wa_req with adr=1, dat=7 -> wa_gnt; mem_wr_en=1, mem_wr_adr=1, mem_dat_in=7 next cycle. Two cycles later ra_req adr=1 -> ra_vld=1, rd_dat=7 exactly RD_LAT+1 cycles after ra_gnt.
- Contention: wa_req and wb_req held high for 4 cycles with data 10/20 to adr 2/3 -> grants A,B,A,B. Memory writes 10@2, 20@3, 10@2, 20@3.
- Read fairness and tags: ra (adr 2) and rb (adr 3) held high after the above -> alternating ra_vld/rb_vld with rd_dat 10/20; never both vld in the same cycle.
- Same-cycle hazard: mem[5]=1; write 9@5 and read @5 granted together -> rd_dat=1 without DPMEM_ARB_WR_FWD_EN, rd_dat=9 with it.
- Reset mid-read: ra_gnt issued, reset pulsed low before vld -> no ra_vld after release, mem_wr_en=0, pointers at A.

Source files
------------

// File: rtl/dpmem_arbiter.sv
// Round-robin arbiter sharing one dual-port memory between two writers and two readers.
// Optional write-to-read forwarding is enabled by defining DPMEM_ARB_WR_FWD_EN.
module dpmem_arbiter #(
   parameter int DW     = 16,
   parameter int AW     = 10,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wa_req,
   input  logic [AW-1:0] wa_adr,
   input  logic [DW-1:0] wa_dat,
   output logic          wa_gnt,
   input  logic          wb_req,
   input  logic [AW-1:0] wb_adr,
   input  logic [DW-1:0] wb_dat,
   output logic          wb_gnt,
   input  logic          ra_req,
   input  logic [AW-1:0] ra_adr,
   output logic          ra_gnt,
   output logic          ra_vld,
   input  logic          rb_req,
   input  logic [AW-1:0] rb_adr,
   output logic          rb_gnt,
   output logic          rb_vld,
   output logic [DW-1:0] rd_dat,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_adr,
   output logic [DW-1:0] mem_dat_in,
   output logic [AW-1:0] mem_rd_adr,
   input  logic [DW-1:0] mem_dat_out
);

   typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_e;

   side_e           wr_ptr, rd_ptr;
   logic [RD_LAT:0] tag_a, tag_b;
   logic [DW-1:0]   ret_dat;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wa_gnt = 1'b0;
      wb_gnt = 1'b0;
      ra_gnt = 1'b0;
      rb_gnt = 1'b0;
      if (reset) begin
         wa_gnt = wa_req && (!wb_req || wr_ptr == SIDE_A);
         wb_gnt = wb_req && !wa_gnt;
         ra_gnt = ra_req && (!rb_req || rd_ptr == SIDE_A);
         rb_gnt = rb_req && !ra_gnt;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= SIDE_A;
         mem_wr_en  <= 1'b0;
         mem_wr_adr <= '0;
         mem_dat_in <= '0;
      end else begin
         mem_wr_en <= wa_gnt || wb_gnt;
         if (wa_gnt) begin
            mem_wr_adr <= wa_adr;
            mem_dat_in <= wa_dat;
            wr_ptr     <= SIDE_B;
         end else if (wb_gnt) begin
            mem_wr_adr <= wb_adr;
            mem_dat_in <= wb_dat;
            wr_ptr     <= SIDE_A;
         end
      end
   end

   // mem_dat_out is sampled on the edge RD_LAT clocks after the one that registers mem_rd_adr,
   // which is also the edge that raises the matching vld.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= SIDE_A;
         mem_rd_adr <= '0;
         tag_a      <= '0;
         tag_b      <= '0;
         rd_dat     <= '0;
      end else begin
         tag_a <= {tag_a[RD_LAT-1:0], ra_gnt};
         tag_b <= {tag_b[RD_LAT-1:0], rb_gnt};
         if (ra_gnt) begin
            mem_rd_adr <= ra_adr;
            rd_ptr     <= SIDE_B;
         end else if (rb_gnt) begin
            mem_rd_adr <= rb_adr;
            rd_ptr     <= SIDE_A;
         end
         if (tag_a[RD_LAT-1] || tag_b[RD_LAT-1])
            rd_dat <= ret_dat;
      end
   end

   assign ra_vld = tag_a[RD_LAT];
   assign rb_vld = tag_b[RD_LAT];

`ifdef DPMEM_ARB_WR_FWD_EN
   logic            fwd_hit;
   logic [DW-1:0]   fwd_src;
   logic [AW-1:0]   rd_adr_sel;
   logic [AW-1:0]   wr_adr_sel;
   logic [DW-1:0]   wr_dat_sel;
   logic [RD_LAT-1:0] fwd_v;
   logic [DW-1:0]   fwd_d [RD_LAT];

   // Catch a write granted alongside the read, or one granted the cycle before (now on mem_wr_*).
   always_comb begin
      rd_adr_sel = ra_gnt ? ra_adr : rb_adr;
      wr_adr_sel = wa_gnt ? wa_adr : wb_adr;
      wr_dat_sel = wa_gnt ? wa_dat : wb_dat;
      fwd_hit    = 1'b0;
      fwd_src    = wr_dat_sel;
      if (ra_gnt || rb_gnt) begin
         if ((wa_gnt || wb_gnt) && wr_adr_sel == rd_adr_sel) begin
            fwd_hit = 1'b1;
         end else if (mem_wr_en && mem_wr_adr == rd_adr_sel) begin
            fwd_hit = 1'b1;
            fwd_src = mem_dat_in;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_v <= '0;
         for (int i = 0; i < RD_LAT; i++) fwd_d[i] <= '0;
      end else begin
         fwd_v[0] <= fwd_hit;
         fwd_d[0] <= fwd_src;
         for (int i = 1; i < RD_LAT; i++) begin
            fwd_v[i] <= fwd_v[i-1];
            fwd_d[i] <= fwd_d[i-1];
         end
      end
   end

   assign ret_dat = fwd_v[RD_LAT-1] ? fwd_d[RD_LAT-1] : mem_dat_out;
`else
   assign ret_dat = mem_dat_out;
`endif

endmodule

// File: tb/tb_dpmem_arbiter.sv
// Directed self-checking bench for dpmem_arbiter with a single-cycle memory model (RD_LAT=1).
module tb_dpmem_arbiter;

   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          wa_req, wb_req, ra_req, rb_req;
   logic [AW-1:0] wa_adr, wb_adr, ra_adr, rb_adr;
   logic [DW-1:0] wa_dat, wb_dat;
   logic          wa_gnt, wb_gnt, ra_gnt, rb_gnt, ra_vld, rb_vld;
   logic [DW-1:0] rd_dat;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_adr, mem_rd_adr;
   logic [DW-1:0] mem_dat_in, mem_dat_out;

   logic [DW-1:0] mem [1024];
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] hazard_exp;

   dpmem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .wa_req(wa_req), .wa_adr(wa_adr), .wa_dat(wa_dat), .wa_gnt(wa_gnt),
      .wb_req(wb_req), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_gnt(wb_gnt),
      .ra_req(ra_req), .ra_adr(ra_adr), .ra_gnt(ra_gnt), .ra_vld(ra_vld),
      .rb_req(rb_req), .rb_adr(rb_adr), .rb_gnt(rb_gnt), .rb_vld(rb_vld),
      .rd_dat(rd_dat),
      .mem_wr_en(mem_wr_en), .mem_wr_adr(mem_wr_adr), .mem_dat_in(mem_dat_in),
      .mem_rd_adr(mem_rd_adr), .mem_dat_out(mem_dat_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: write on the clock edge, read address decoded within the cycle.
   always @(posedge clk) if (mem_wr_en) mem[mem_wr_adr] <= mem_dat_in;
   assign mem_dat_out = mem[mem_rd_adr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      wa_req = 1'b0; wb_req = 1'b0; ra_req = 1'b0; rb_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
`ifdef DPMEM_ARB_WR_FWD_EN
      hazard_exp = 16'd9;
`else
      hazard_exp = 16'd1;
`endif
      reset = 1'b0;
      wa_req = 1'b1; wb_req = 1'b1; ra_req = 1'b1; rb_req = 1'b1;
      wa_adr = '0; wb_adr = '0; ra_adr = '0; rb_adr = '0;
      wa_dat = '0; wb_dat = '0;

      // Reset held with every request high
      #1;
      check("rst_wa_gnt", wa_gnt, 0);
      check("rst_wb_gnt", wb_gnt, 0);
      check("rst_ra_gnt", ra_gnt, 0);
      check("rst_rb_gnt", rb_gnt, 0);
      step(); step();
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_ra_vld", ra_vld, 0);
      check("rst_rb_vld", rb_vld, 0);
      check("rst_rd_dat", rd_dat, 0);
      check("rst_rd_adr", mem_rd_adr, 0);

      // Release: both pointers start at A
      reset = 1'b1;
      #1;
      check("rel_wa_gnt", wa_gnt, 1);
      check("rel_wb_gnt", wb_gnt, 0);
      check("rel_ra_gnt", ra_gnt, 1);
      check("rel_rb_gnt", rb_gnt, 0);
      clear_reqs();
      step();

      // Single write 7@1 from A
      wa_req = 1'b1; wa_adr = 10'd1; wa_dat = 16'd7;
      #1 check("w1_gnt", wa_gnt, 1);
      step(); clear_reqs();
      check("w1_wr_en", mem_wr_en, 1);
      check("w1_wr_adr", mem_wr_adr, 1);
      check("w1_dat_in", mem_dat_in, 7);
      step();
      check("w1_wr_en_off", mem_wr_en, 0);

      // Read @1 from A: vld two cycles after the grant
      ra_req = 1'b1; ra_adr = 10'd1;
      #1 check("r1_gnt", ra_gnt, 1);
      step(); clear_reqs();
      check("r1_rd_adr", mem_rd_adr, 1);
      check("r1_vld_early", ra_vld, 0);
      step();
      check("r1_vld", ra_vld, 1);
      check("r1_rb_vld", rb_vld, 0);
      check("r1_dat", rd_dat, 7);
      step();
      check("r1_vld_off", ra_vld, 0);
      check("r1_dat_hold", rd_dat, 7);

      // Writer B stores 1@5; write pointer returns to A
      wb_req = 1'b1; wb_adr = 10'd5; wb_dat = 16'd1;
      #1 check("w5_gnt", wb_gnt, 1);
      step(); clear_reqs();
      step();

      // Reader B reads @5; read pointer returns to A
      rb_req = 1'b1; rb_adr = 10'd5;
      #1 check("r5_gnt", rb_gnt, 1);
      step(); clear_reqs();
      step();
      check("r5_vld", rb_vld, 1);
      check("r5_ra_vld", ra_vld, 0);
      check("r5_dat", rd_dat, 1);

      // Write contention: A,B,A,B
      wa_req = 1'b1; wa_adr = 10'd2; wa_dat = 16'd10;
      wb_req = 1'b1; wb_adr = 10'd3; wb_dat = 16'd20;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("wc%0d_wa_gnt", k), wa_gnt, (k % 2 == 0) ? 1 : 0);
         check($sformatf("wc%0d_wb_gnt", k), wb_gnt, (k % 2 == 0) ? 0 : 1);
         step();
         check($sformatf("wc%0d_wr_en", k), mem_wr_en, 1);
         check($sformatf("wc%0d_wr_adr", k), mem_wr_adr, (k % 2 == 0) ? 2 : 3);
         check($sformatf("wc%0d_dat_in", k), mem_dat_in, (k % 2 == 0) ? 10 : 20);
      end
      clear_reqs();

      // Read contention: grants in cycles 0..3, vld in cycles 2..5, alternating tags
      ra_req = 1'b1; ra_adr = 10'd2;
      rb_req = 1'b1; rb_adr = 10'd3;
      for (int k = 0; k < 6; k++) begin
         int  c;
         logic exp_a, exp_b;
         if (k < 4) begin
            #1;
            check($sformatf("rc%0d_ra_gnt", k), ra_gnt, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rc%0d_rb_gnt", k), rb_gnt, (k % 2 == 0) ? 0 : 1);
         end else begin
            clear_reqs();
         end
         step();
         c = k + 1;
         exp_a = (c >= 2 && c <= 5 && (c - 2) % 2 == 0);
         exp_b = (c >= 2 && c <= 5 && (c - 2) % 2 == 1);
         check($sformatf("rc%0d_ra_vld", c), ra_vld, exp_a);
         check($sformatf("rc%0d_rb_vld", c), rb_vld, exp_b);
         if (exp_a) check($sformatf("rc%0d_dat", c), rd_dat, 10);
         if (exp_b) check($sformatf("rc%0d_dat", c), rd_dat, 20);
      end

      // Same-cycle write 9@5 and read @5
      wa_req = 1'b1; wa_adr = 10'd5; wa_dat = 16'd9;
      ra_req = 1'b1; ra_adr = 10'd5;
      #1;
      check("hz_wa_gnt", wa_gnt, 1);
      check("hz_ra_gnt", ra_gnt, 1);
      step(); clear_reqs();
      step();
      check("hz_vld", ra_vld, 1);
      check("hz_dat", rd_dat, hazard_exp);

      // Later read @5 sees the committed write
      ra_req = 1'b1; ra_adr = 10'd5;
      #1 check("hz2_gnt", ra_gnt, 1);
      step(); clear_reqs();
      step();
      check("hz2_vld", ra_vld, 1);
      check("hz2_dat", rd_dat, 9);

      // Reset mid-operation: write 55@7 and read @2 granted, then reset before vld
      wa_req = 1'b1; wa_adr = 10'd7; wa_dat = 16'd55;
      ra_req = 1'b1; ra_adr = 10'd2;
      #1;
      check("mr_wa_gnt", wa_gnt, 1);
      check("mr_ra_gnt", ra_gnt, 1);
      step(); clear_reqs();
      check("mr_wr_en_pre", mem_wr_en, 1);
      #1 reset = 1'b0;
      #1;
      check("mr_wr_en_rst", mem_wr_en, 0);
      #1 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("mr%0d_ra_vld", k), ra_vld, 0);
         check($sformatf("mr%0d_wr_en", k), mem_wr_en, 0);
      end
      check("mr_mem7", mem[7], 0);
      wa_req = 1'b1; wb_req = 1'b1; ra_req = 1'b1; rb_req = 1'b1;
      #1;
      check("mr_wa_gnt_ptr", wa_gnt, 1);
      check("mr_wb_gnt_ptr", wb_gnt, 0);
      check("mr_ra_gnt_ptr", ra_gnt, 1);
      check("mr_rb_gnt_ptr", rb_gnt, 0);
      clear_reqs();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
